mod_msg_scheduler: RTL and testbench

SHA-256 message schedule generator and the producer side of the compressor's per-round word interface. It accepts one 512-bit block as sixteen 32-bit words over a valid/ready load port, then streams W[0..63] with round index I at one word per cycle. It sits between the padding/block buffer and the compressor and replaces the testbench-side W memory. The compressor consumes W_OUT/I_OUT/K_OUT directly.

---
 rtl/mod_msg_scheduler.sv | 169 ++++++++++++++++
 tb/tb_mod_msg_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_msg_scheduler.sv
// SHA-256 message schedule generator: loads a 16-word block, then streams W[0..63] with round index.
// Optional MSG_SCHED_K_ROM_EN: internal K constant ROM drives K_OUT; otherwise K_OUT is tied to zero.
module mod_msg_scheduler (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD_VALID,
    output logic        LOAD_READY,
    input  logic [31:0] LOAD_WORD,
    input  logic        STALL,
    output logic        W_VALID,
    output logic [31:0] W_OUT,
    output logic [5:0]  I_OUT,
    output logic [31:0] K_OUT,
    output logic        DONE
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [31:0] win_r [16];
    logic [31:0] w_out_r;
    logic [5:0]  i_out_r;
    logic        done_r;
    logic        accept_s;
    logic        last_word_s;
    logic        advance_s;
    logic        last_round_s;
    logic [31:0] w_next_s;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

`ifdef MSG_SCHED_K_ROM_EN
    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        case (idx)
            6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
            default: k = 32'h00000000;
        endcase
        return k;
    endfunction
`endif

    // Control decode and next-state selection
    always_comb begin
        accept_s     = (state_r == ST_LOAD) && LOAD_VALID;
        last_word_s  = accept_s && (cnt_r == 4'd15);
        advance_s    = (state_r == ST_RUN) && !STALL;
        last_round_s = advance_s && (i_out_r == 6'd63);
        w_next_s     = sigma1(win_r[14]) + win_r[9] + sigma0(win_r[1]) + win_r[0];
        state_s      = state_r;
        case (state_r)
            ST_LOAD: begin
                if (last_word_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (last_round_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Load word counter; wraps to zero on the 16th accept
    always_ff @(posedge CLK) begin
        if (RESET || last_round_s) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= cnt_r + 4'd1;
        end
    end

    // Schedule window: filled by slot during load, shifted down one slot per round
    always_ff @(posedge CLK) begin
        if (accept_s) begin
            win_r[cnt_r] <= LOAD_WORD;
        end else if (advance_s) begin
            for (int i = 0; i < 15; i++) begin
                win_r[i] <= win_r[i + 1];
            end
            win_r[15] <= w_next_s;
        end
    end

    // Registered stream outputs; slot 1 becomes the next W_OUT when the window shifts
    always_ff @(posedge CLK) begin
        if (RESET) begin
            w_out_r <= 32'h00000000;
            i_out_r <= 6'd0;
            done_r  <= 1'b0;
        end else begin
            done_r <= last_round_s;
            if (last_word_s) begin
                w_out_r <= win_r[0];
                i_out_r <= 6'd0;
            end else if (advance_s) begin
                w_out_r <= win_r[1];
                i_out_r <= i_out_r + 6'd1;
            end
        end
    end

`ifdef MSG_SCHED_K_ROM_EN
    logic [31:0] k_out_r;

    // Round constant registered alongside W_OUT
    always_ff @(posedge CLK) begin
        if (RESET) begin
            k_out_r <= 32'h00000000;
        end else if (last_word_s) begin
            k_out_r <= k_rom(6'd0);
        end else if (advance_s) begin
            k_out_r <= k_rom(i_out_r + 6'd1);
        end
    end

    assign K_OUT = k_out_r;
`else
    assign K_OUT = 32'h00000000;
`endif

    assign LOAD_READY = (state_r == ST_LOAD);
    assign W_VALID    = (state_r == ST_RUN);
    assign W_OUT      = w_out_r;
    assign I_OUT      = i_out_r;
    assign DONE       = done_r;

endmodule

// File: tb/tb_mod_msg_scheduler.sv
// Randomized self-checking bench for mod_msg_scheduler against an array-based SHA-256 schedule model.
module tb_mod_msg_scheduler;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        LOAD_VALID;
    logic        LOAD_READY;
    logic [31:0] LOAD_WORD;
    logic        STALL;
    logic        W_VALID;
    logic [31:0] W_OUT;
    logic [5:0]  I_OUT;
    logic [31:0] K_OUT;
    logic        DONE;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];

    mod_msg_scheduler dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .LOAD_WORD  (LOAD_WORD),
        .STALL      (STALL),
        .W_VALID    (W_VALID),
        .W_OUT      (W_OUT),
        .I_OUT      (I_OUT),
        .K_OUT      (K_OUT),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_sched();
        for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic set_hello();
        blk[0] = 32'h48656c6c; blk[1] = 32'h6f20776f; blk[2] = 32'h726c6421; blk[3] = 32'h80000000;
        for (int t = 4; t < 15; t++) blk[t] = 32'h00000000;
        blk[15] = 32'h00000060;
        build_sched();
    endtask

    task automatic set_random();
        for (int t = 0; t < 16; t++) blk[t] = $urandom;
        build_sched();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 32'(LOAD_READY), 32'd1);
        chk({tag, "_wvalid"}, 32'(W_VALID), 32'd0);
        chk({tag, "_wout"}, W_OUT, 32'h00000000);
        chk({tag, "_iout"}, 32'(I_OUT), 32'd0);
        chk({tag, "_kout"}, K_OUT, 32'h00000000);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
    endtask

    // Present n words of blk; gaps inserts idle cycles, STALL is randomized (must be ignored)
    task automatic load_words(input int n, input bit gaps);
        int acc = 0;
        int cyc = 0;
        bit ph = 1'b0;
        while (acc < n && cyc < 100) begin
            LOAD_VALID = gaps ? ph : 1'b1;
            ph = ~ph;
            LOAD_WORD = blk[acc];
            STALL = 1'($urandom_range(0, 1));
            chk("load_ready", 32'(LOAD_READY), 32'd1);
            chk("load_wvalid", 32'(W_VALID), 32'd0);
            tick();
            if (LOAD_VALID) acc++;
            cyc++;
        end
        LOAD_VALID = 1'b0;
        LOAD_WORD = 32'h00000000;
        STALL = 1'b0;
        if (acc < n) chk("load_timeout", 32'(acc), 32'(n));
    endtask

    // Consume the stream and compare against the model; optional stall, mid-stream reset, RUN-time writes
    task automatic stream(input int stall_at, input int stall_len, input int reset_at,
                          input bit inject, input bit hello);
        int idx = 0;
        int cyc = 0;
        int st = 0;
        while (idx < 64 && cyc < 300) begin
            chk("w_valid", 32'(W_VALID), 32'd1);
            chk("i_out", 32'(I_OUT), 32'(idx));
            chk("w_out", W_OUT, exp_w[idx]);
            chk("done_in_run", 32'(DONE), 32'd0);
            chk("ready_in_run", 32'(LOAD_READY), 32'd0);
`ifdef MSG_SCHED_K_ROM_EN
            if (idx == 0) chk("k_round0", K_OUT, 32'h428a2f98);
            if (idx == 63) chk("k_round63", K_OUT, 32'hc67178f2);
`else
            chk("k_zero", K_OUT, 32'h00000000);
`endif
            if (hello && idx == 16) chk("hello_w16", W_OUT, 32'h17470237);
            if (inject) begin
                LOAD_VALID = 1'b1;
                LOAD_WORD = 32'hdeadbeef;
            end
            STALL = (idx == stall_at) && (st < stall_len);
            if (idx == reset_at) begin
                RESET = 1'b1;
                STALL = 1'b0;
                tick();
                RESET = 1'b0;
                LOAD_VALID = 1'b0;
                check_idle("midreset");
                tick();
                chk("midreset_nodone", 32'(DONE), 32'd0);
                return;
            end
            tick();
            cyc++;
            if (STALL) st++;
            else idx++;
        end
        STALL = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_WORD = 32'h00000000;
        if (idx < 64) chk("stream_timeout", 32'(idx), 32'd64);
        chk("done_pulse", 32'(DONE), 32'd1);
        chk("done_latency", 32'(cyc), 32'(64 + stall_len));
        chk("after_wvalid", 32'(W_VALID), 32'd0);
        chk("after_ready", 32'(LOAD_READY), 32'd1);
        tick();
        chk("done_single", 32'(DONE), 32'd0);
    endtask

    initial begin
        RESET = 1'b1;
        LOAD_VALID = 1'b0;
        LOAD_WORD = 32'h00000000;
        STALL = 1'b0;
        tick();
        tick();
        check_idle("reset");
        RESET = 1'b0;
        tick();
        check_idle("idle");

        set_hello();
        load_words(16, 1'b0);
        stream(99, 0, 99, 1'b0, 1'b1);

        for (int t = 0; t < 16; t++) blk[t] = 32'h00000000;
        build_sched();
        load_words(16, 1'b0);
        stream(99, 0, 99, 1'b0, 1'b0);

        set_hello();
        load_words(16, 1'b0);
        stream(20, 5, 99, 1'b0, 1'b1);

        set_random();
        load_words(16, 1'b1);
        stream(99, 0, 99, 1'b1, 1'b0);

        set_hello();
        load_words(16, 1'b0);
        stream(99, 0, 30, 1'b0, 1'b1);
        load_words(16, 1'b0);
        stream(99, 0, 99, 1'b0, 1'b1);

        set_random();
        load_words(7, 1'b0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_idle("loadreset");
        set_hello();
        load_words(16, 1'b0);
        stream(99, 0, 99, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            set_random();
            load_words(16, 1'($urandom_range(0, 1)));
            stream(int'($urandom_range(0, 63)), int'($urandom_range(1, 4)), 99,
                   1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
